// File: rtl/fetch_pkg.sv
// Fetch-stage shared types: FSM states, prefetch entry layout and the NOP encoding.
`ifndef INST_LEN
`include "constants.sv"
`endif

package fetch_pkg;

  typedef enum logic [1:0] {BOOT, RUN, DRAIN} fetch_state_e;

  typedef struct packed {
    logic [15:0]           pc;
    logic [`INST_LEN-1:0]  instr;
  } fetch_entry_t;

  localparam logic [`INST_LEN-1:0] NOP_INSTR = '0;

endpackage

// File: rtl/constants.sv
// Codebase-wide constants shared by the pipeline stages.
`ifndef INST_LEN
`define INST_LEN 16
`endif

// File: rtl/fetch_fifo.sv
// In-order prefetch FIFO (DEPTH a power of 2): a pushed entry is visible at the head the next cycle.
// Push when full and pop when empty are ignored; flush empties it in one cycle.
module fetch_fifo #(
  parameter int  DEPTH   = 2,
  parameter type entry_t = logic [31:0]
) (
  input  logic                     clk,
  input  logic                     nReset,
  input  logic                     push,
  input  entry_t                   push_data,
  input  logic                     pop,
  input  logic                     flush,
  output entry_t                   head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  entry_t        mem [DEPTH];
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count + CW'(do_push) - CW'(do_pop);
    end
  end

  // Payload storage needs no reset: the head is only consumed while count is non-zero.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction fetch: owns the PC, imem req/gnt/rvalid handshake and prefetch FIFO; gnt N + rvalid N+1 -> inst_valid N+2.
// Stall holds the presented entry, redirect flushes and refetches; IF_PERF_CNT_EN adds push/redirect counters.
module if_fetch_unit
  import fetch_pkg::*;
#(
  parameter logic [15:0] RESET_VECTOR = 16'h0000,
  parameter int          FIFO_DEPTH   = 2,
  parameter int          MAX_OUTSTAND = 2
) (
  input  logic        clk,
  input  logic        nReset,
  output logic        imem_req,
  output logic [15:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [15:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [15:0] redirect_pc,
  input  logic        stall,
  output logic [15:0] PC_Out,
  output logic [15:0] Instruction_Out,
  output logic        inst_valid
`ifdef IF_PERF_CNT_EN
  ,
  output logic [15:0] perf_fetch_cnt,
  output logic [15:0] perf_flush_cnt
`endif
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam int OW = $clog2(MAX_OUTSTAND + 1);
  localparam int SW = (MAX_OUTSTAND > 1) ? $clog2(MAX_OUTSTAND) : 1;

  fetch_state_e  state;
  fetch_state_e  state_next;
  logic [15:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [OW-1:0] outstanding_next;
  logic [OW-1:0] discard;
  logic [OW-1:0] discard_next;
  logic          fire;
  logic          rsp;
  logic          drop_dec;
  logic          push;
  logic          pop;
  logic [7:0]    occupancy;
  fetch_entry_t  head;
  fetch_entry_t  push_data;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;
  logic [15:0]   shadow_pc [MAX_OUTSTAND];
  logic [SW-1:0] sh_wr;
  logic [SW-1:0] sh_rd;

  function automatic logic [SW-1:0] sh_inc(input logic [SW-1:0] p);
    return (p == SW'(MAX_OUTSTAND - 1)) ? '0 : p + SW'(1);
  endfunction

  // A response with nothing outstanding can only be left over from before a reset.
  assign fire      = imem_req && imem_gnt;
  assign rsp       = imem_rvalid && (outstanding != '0);
  assign drop_dec  = rsp && (discard != '0);
  assign push      = rsp && !drop_dec && !redirect_valid;
  assign pop       = inst_valid && !stall && !redirect_valid;
  assign occupancy = 8'(fifo_count) + 8'(outstanding);
  assign push_data = '{pc: shadow_pc[sh_rd], instr: imem_rdata};

  assign outstanding_next = outstanding + OW'(fire) - OW'(rsp);

  always_comb begin
    discard_next = discard - OW'(drop_dec);
    if (redirect_valid && state != DRAIN) discard_next = outstanding_next;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) state <= BOOT;
    else         state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      BOOT:    state_next = RUN;
      RUN:     if (redirect_valid && outstanding_next != '0) state_next = DRAIN;
      DRAIN:   if (discard_next == '0) state_next = RUN;
      default: state_next = BOOT;
    endcase
  end

  // Counting outstanding requests against FIFO space keeps every return pushable.
  always_comb begin
    imem_req        = (state == RUN) && !redirect_valid &&
                      (occupancy < 8'(FIFO_DEPTH)) && (outstanding < OW'(MAX_OUTSTAND));
    imem_addr       = fetch_pc;
    inst_valid      = !fifo_empty;
    PC_Out          = fifo_empty ? 16'h0000 : head.pc;
    Instruction_Out = fifo_empty ? NOP_INSTR : head.instr;
  end

  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      fetch_pc    <= RESET_VECTOR;
      outstanding <= '0;
      discard     <= '0;
      sh_wr       <= '0;
      sh_rd       <= '0;
    end else begin
      outstanding <= outstanding_next;
      discard     <= discard_next;
      if (redirect_valid) fetch_pc <= redirect_pc;
      else if (fire)      fetch_pc <= fetch_pc + 16'd1;
      if (fire) sh_wr <= sh_inc(sh_wr);
      if (rsp)  sh_rd <= sh_inc(sh_rd);
    end
  end

  always_ff @(posedge clk) begin
    if (fire) shadow_pc[sh_wr] <= fetch_pc;
  end

  fetch_fifo #(
    .DEPTH   (FIFO_DEPTH),
    .entry_t (fetch_entry_t)
  ) u_fifo (
    .clk       (clk),
    .nReset    (nReset),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .flush     (redirect_valid),
    .head      (head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (nReset) assert (!(push && fifo_full));
  end
`endif

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      perf_fetch_cnt <= '0;
      perf_flush_cnt <= '0;
    end else begin
      if (push && perf_fetch_cnt != 16'hFFFF)           perf_fetch_cnt <= perf_fetch_cnt + 16'd1;
      if (redirect_valid && perf_flush_cnt != 16'hFFFF) perf_flush_cnt <= perf_flush_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_if_fetch_unit.sv
// Bench for if_fetch_unit: randomized memory/stall/redirect traffic against a PC-stream reference model.
`timescale 1ns/1ps
module tb_if_fetch_unit;
  import fetch_pkg::*;

  localparam logic [15:0] RV   = 16'h0000;
  localparam int          MAXO = 2;

  logic        clk = 1'b0;
  logic        nReset = 1'b0;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        stall = 1'b0;
  logic [15:0] PC_Out;
  logic [15:0] Instruction_Out;
  logic        inst_valid;
`ifdef IF_PERF_CNT_EN
  logic [15:0] perf_fetch_cnt;
  logic [15:0] perf_flush_cnt;
`endif

  if_fetch_unit #(.RESET_VECTOR(RV), .FIFO_DEPTH(2), .MAX_OUTSTAND(MAXO)) dut (
    .clk(clk), .nReset(nReset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .stall(stall),
    .PC_Out(PC_Out), .Instruction_Out(Instruction_Out), .inst_valid(inst_valid)
`ifdef IF_PERF_CNT_EN
    , .perf_fetch_cnt(perf_fetch_cnt), .perf_flush_cnt(perf_flush_cnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [15:0] t;
    t = a * 16'h9E37;
    return t ^ 16'h5A5A;
  endfunction

  // Memory model: in-order responses, 1..max_lat cycles after the grant.
  typedef struct { logic [15:0] addr; int ready; } pend_t;
  pend_t pq[$];
  int gnt_pct = 100;
  int max_lat = 1;

  always @(negedge clk) begin
    if (!nReset) begin
      pq.delete();
      imem_gnt    = 1'b0;
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = '0;
      if (pq.size() > 0 && pq[0].ready <= cyc) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_word(pq[0].addr);
        void'(pq.pop_front());
      end
      imem_gnt = imem_req && ($urandom_range(99) < gnt_pct);
      if (imem_gnt) pq.push_back('{imem_addr, cyc + $urandom_range(max_lat, 1)});
    end
  end

  // Reference model: the presented stream is consecutive PCs from the last redirect target.
  logic [15:0] redir_q[$];
  logic [15:0] exp_pc, exp_fetch, last_gnt_addr, tgt, redir_first_pc;
  int  mo, md, pops, drain_cycles, first_gnt, first_vld, first_vld_pc;
  int  pushes, flushes;
  bit  prev_redirect, cap, saw_wrap;

  always @(negedge clk) begin
    #2;
    if (!nReset) begin
      exp_pc = RV; exp_fetch = RV; mo = 0; md = 0; pops = 0;
      first_gnt = -1; first_vld = -1; first_vld_pc = -1;
      pushes = 0; flushes = 0; prev_redirect = 1'b0; cap = 1'b0;
      last_gnt_addr = 16'h1234;
    end else begin
      if (prev_redirect) chk("vld_after_redirect", inst_valid, 0);
      if (inst_valid) begin
        chk("pc_out", PC_Out, exp_pc);
        chk("instr_out", Instruction_Out, mem_word(exp_pc));
        if (first_vld < 0) begin first_vld = cyc; first_vld_pc = PC_Out; end
        if (cap) begin redir_first_pc = PC_Out; cap = 1'b0; end
      end else begin
        chk("nop_when_invalid", Instruction_Out, NOP_INSTR);
      end
      if (redirect_valid) chk("no_req_on_redirect", imem_req, 0);
      if (imem_req) chk("req_within_limit", mo < MAXO, 1);
      if (dut.state == DRAIN) drain_cycles++;
      if (imem_req && imem_gnt) begin
        chk("fetch_addr", imem_addr, exp_fetch);
        if (first_gnt < 0) first_gnt = cyc;
        if (last_gnt_addr == 16'hFFFF && imem_addr == 16'h0000) saw_wrap = 1'b1;
        last_gnt_addr = imem_addr;
        exp_fetch = exp_fetch + 16'd1;
        mo++;
      end
      if (imem_rvalid) begin
        mo--;
        if (md > 0) md--;
        else if (!redirect_valid) pushes++;
      end
      if (inst_valid && !stall && !redirect_valid) begin
        exp_pc = exp_pc + 16'd1;
        pops++;
      end
      if (redirect_valid) begin
        if (redir_q.size() == 0) chk("redirect_expected", 1, 0);
        else begin
          tgt = redir_q.pop_front();
          exp_pc = tgt; exp_fetch = tgt; md = mo; cap = 1'b1;
        end
        flushes++;
      end
      prev_redirect = redirect_valid;
    end
  end

  task automatic redirect_now(input logic [15:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    redir_q.push_back(pc);
  endtask

  task automatic reset_outputs_check(input string tag);
    chk({tag, "_req"}, imem_req, 0);
    chk({tag, "_addr"}, imem_addr, RV);
    chk({tag, "_pc"}, PC_Out, 0);
    chk({tag, "_instr"}, Instruction_Out, 0);
    chk({tag, "_vld"}, inst_valid, 0);
`ifdef IF_PERF_CNT_EN
    chk({tag, "_perf_fetch"}, perf_fetch_cnt, 0);
    chk({tag, "_perf_flush"}, perf_flush_cnt, 0);
`endif
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not end in time");
    $fatal(1);
  end

  initial begin
    int d0;
    bit hit;
    repeat (3) @(posedge clk);
    #1 reset_outputs_check("reset");

    // 1: zero-wait memory, no stall
    @(posedge clk); #1 nReset = 1'b1;
    @(negedge clk); #3 chk("boot_no_req", imem_req, 0);
    repeat (30) @(posedge clk);
    chk("first_latency", first_vld - first_gnt, 2);
    chk("first_pc", first_vld_pc, RV);
    chk("throughput", pops >= 15, 1);

    // 2: stall with FIFO filling
    #1 stall = 1'b1;
    repeat (5) @(posedge clk);
    @(negedge clk); #3;
    chk("stall_valid_held", inst_valid, 1);
    chk("stall_full_no_req", imem_req, 0);
    @(posedge clk); #1 stall = 1'b0;
    repeat (10) @(posedge clk);

    // 3: redirect with two requests outstanding
    max_lat = 4;
    d0 = drain_cycles;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (mo == 2) begin hit = 1'b1; break; end
    end
    chk("t3_two_outstanding", hit, 1);
    redirect_now(16'h0040);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (30) @(posedge clk);
    chk("t3_first_pc", redir_first_pc, 16'h0040);
    chk("t3_drain_visited", drain_cycles > d0, 1);

    // 4: redirect coinciding with rvalid and stall
    max_lat = 1;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (pq.size() > 0 && pq[0].ready <= cyc && md == 0) begin hit = 1'b1; break; end
    end
    chk("t4_aligned", hit, 1);
    stall = 1'b1;
    redirect_now(16'h1234);
    @(negedge clk); #3 chk("t4_rvalid_present", imem_rvalid, 1);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 stall = 1'b0;
    repeat (20) @(posedge clk);
    chk("t4_first_pc", redir_first_pc, 16'h1234);

    // 5: PC wrap
    #1 redirect_now(16'hFFFF);
    @(posedge clk); #1 redirect_valid = 1'b0;
    repeat (20) @(posedge clk);
    chk("t5_wrap", saw_wrap, 1);

    // random traffic
    gnt_pct = 70; max_lat = 3;
    for (int i = 0; i < 1500; i++) begin
      @(posedge clk); #1;
      stall = ($urandom_range(3) == 0);
      if ($urandom_range(24) == 0) redirect_now(16'($urandom));
      else redirect_valid = 1'b0;
    end
    @(posedge clk); #1 stall = 1'b0; redirect_valid = 1'b0;
    repeat (15) @(posedge clk);
`ifdef IF_PERF_CNT_EN
    chk("perf_fetch", perf_fetch_cnt, (pushes > 65535) ? 16'hFFFF : 16'(pushes));
    chk("perf_flush", perf_flush_cnt, (flushes > 65535) ? 16'hFFFF : 16'(flushes));
`endif

    // 6: reset mid-stream with two outstanding
    gnt_pct = 100; max_lat = 4;
    hit = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge clk); #1;
      if (mo == 2) begin hit = 1'b1; break; end
    end
    chk("t6_two_outstanding", hit, 1);
    nReset = 1'b0;
    #1 reset_outputs_check("midreset");
    repeat (2) @(posedge clk);
    #1 nReset = 1'b1;
    hit = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk); #3;
      if (imem_req) begin hit = 1'b1; break; end
    end
    chk("t6_req_seen", hit, 1);
    chk("t6_first_addr", imem_addr, RV);
    repeat (20) @(posedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
